// File: rtl/clb_cfg.sv
// clb_cfg: configurable logic block tile.
// Two N_IN-input LUTs (F, G), a set/reset/enable storage element and output
// muxes. All function selects come from a serial configuration chain, and
// tiles daisy-chain through CFG_DOUT.
//
// Ports:
//   K        clock; all state changes on its rising edge
//   RST      synchronous active-high reset
//   IN       user logic inputs [N_IN-1:0]
//   CFG_EN   configuration shift enable
//   CFG_DIN  serial configuration data
//   CFG_DOUT configuration MSB, feeds the next tile's CFG_DIN
//   CFG_DONE high while configured
//   X, Y     user outputs (forced low unless configured)
//   Q        storage element state
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_UNCONF | no configuration since reset
// ST_LOAD   | configuration bits being shifted in (may pause)
// ST_CONF   | fully configured, user logic active

module clb_cfg #(
  parameter int N_IN = 4
) (
  input  logic            K,
  input  logic            RST,
  input  logic [N_IN-1:0] IN,
  input  logic            CFG_EN,
  input  logic            CFG_DIN,
  output logic            CFG_DOUT,
  output logic            CFG_DONE,
  output logic            X,
  output logic            Y,
  output logic            Q
);

  localparam int LUT_BITS = 2 ** N_IN;
  localparam int L        = LUT_BITS;
  localparam int CFG_BITS = 2 * LUT_BITS + 11;
  localparam int CNT_W    = $clog2(CFG_BITS + 1);

  localparam logic [1:0] ST_UNCONF = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_CONF   = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CFG_BITS-1:0] cfg_q, cfg_d;
  logic                q_q, q_d;

  logic [L-1:0]    f_tab, g_tab;
  logic            fbsel;
  logic [1:0]      xsel, ysel, ssel, rsel, esel;
  logic [N_IN-1:0] lut_addr;
  logic            f_val, g_val, s_val, r_val, e_val, x_raw, y_raw;
  logic            conf;

  assign f_tab = cfg_q[L-1:0];
  assign g_tab = cfg_q[2*L-1:L];
  assign fbsel = cfg_q[2*L];
  assign xsel  = cfg_q[2*L+2:2*L+1];
  assign ysel  = cfg_q[2*L+4:2*L+3];
  assign ssel  = cfg_q[2*L+6:2*L+5];
  assign rsel  = cfg_q[2*L+8:2*L+7];
  assign esel  = cfg_q[2*L+10:2*L+9];

  assign conf = (state_q == ST_CONF);

  // Feedback uses the registered Q, so FBSEL never closes a combinational loop.
  assign lut_addr = {IN[N_IN-1:1], (fbsel ? q_q : IN[0])};
  assign f_val    = f_tab[lut_addr];
  assign g_val    = g_tab[lut_addr];

  always_comb begin
    s_val = 1'b0;
    r_val = 1'b0;
    e_val = 1'b1;
    x_raw = 1'b0;
    y_raw = 1'b0;
    case (ssel)
      2'b00:   s_val = IN[N_IN-1];
      2'b01:   s_val = f_val;
      default: s_val = 1'b0;
    endcase
    case (rsel)
      2'b00:   r_val = IN[1];
      2'b01:   r_val = g_val;
      default: r_val = 1'b0;
    endcase
    case (esel)
      2'b00:   e_val = g_val;
      2'b01:   e_val = IN[N_IN-1];
      default: e_val = 1'b1;
    endcase
    case (xsel)
      2'b00:   x_raw = f_val;
      2'b01:   x_raw = g_val;
      default: x_raw = q_q;
    endcase
    case (ysel)
      2'b00:   y_raw = q_q;
      2'b01:   y_raw = g_val;
      default: y_raw = f_val;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cfg_d   = cfg_q;
    q_d     = q_q;
    // The chain shifts in every state so data passes through to downstream tiles.
    if (CFG_EN) begin
      cfg_d = {cfg_q[CFG_BITS-2:0], CFG_DIN};
    end
    case (state_q)
      ST_UNCONF: begin
        if (CFG_EN) begin
          cnt_d   = CNT_W'(1);
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (CFG_EN) begin
          if (cnt_q == CNT_W'(CFG_BITS - 1)) begin
            cnt_d   = '0;
            state_d = ST_CONF;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_CONF: begin
        if (CFG_EN) begin
          // Reconfiguration: this edge already carries the first new bit.
          cnt_d   = CNT_W'(1);
          q_d     = 1'b0;
          state_d = ST_LOAD;
        end else if (e_val) begin
          if (r_val) begin
            q_d = 1'b0;
          end else if (s_val) begin
            q_d = 1'b1;
          end else begin
            q_d = f_val;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        q_d     = 1'b0;
        state_d = ST_UNCONF;
      end
    endcase
  end

  always_ff @(posedge K) begin
    if (RST) begin
      state_q <= ST_UNCONF;
      cnt_q   <= '0;
      cfg_q   <= '0;
      q_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cfg_q   <= cfg_d;
      q_q     <= q_d;
    end
  end

  assign CFG_DOUT = cfg_q[CFG_BITS-1];
  assign CFG_DONE = conf;
  assign X        = conf & x_raw;
  assign Y        = conf & y_raw;
  assign Q        = q_q;

endmodule

// File: tb/tb_clb_cfg.sv
// tb_clb_cfg: directed test of clb_cfg at N_IN=4 (43-bit configuration).
// u0 is the primary tile; u1 is chained from u0's CFG_DOUT for the
// daisy-chain scenario.

module tb_clb_cfg;

  localparam int NB = 43;

  logic       K;
  logic       RST;
  logic [3:0] IN;
  logic       CFG_EN;
  logic       CFG_DIN;
  logic       dout0, done0, x0, y0, q0;
  logic       dout1, done1, x1, y1, q1;

  int n_checks = 0;
  int n_fail   = 0;

  clb_cfg #(.N_IN(4)) u0 (
    .K(K), .RST(RST), .IN(IN), .CFG_EN(CFG_EN), .CFG_DIN(CFG_DIN),
    .CFG_DOUT(dout0), .CFG_DONE(done0), .X(x0), .Y(y0), .Q(q0)
  );

  clb_cfg #(.N_IN(4)) u1 (
    .K(K), .RST(RST), .IN(IN), .CFG_EN(CFG_EN), .CFG_DIN(dout0),
    .CFG_DOUT(dout1), .CFG_DONE(done1), .X(x1), .Y(y1), .Q(q1)
  );

  initial begin
    K = 1'b0;
    forever #5 K = ~K;
  end

  // Field order, MSB first: ESEL RSEL SSEL YSEL XSEL FBSEL G F
  function automatic logic [NB-1:0] mk(input logic [1:0] es, input logic [1:0] rs,
                                       input logic [1:0] ss, input logic [1:0] ys,
                                       input logic [1:0] xs, input logic fb,
                                       input logic [15:0] g, input logic [15:0] f);
    return {es, rs, ss, ys, xs, fb, g, f};
  endfunction

  task automatic tick();
    @(posedge K);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic shift_rng(input logic [NB-1:0] v, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      CFG_EN  = 1'b1;
      CFG_DIN = v[i];
      tick();
    end
    CFG_EN = 1'b0;
  endtask

  task automatic load(input logic [NB-1:0] v);
    shift_rng(v, NB - 1, 1);
    chk("done_before_last_bit", 64'(done0), 64'd0);
    shift_rng(v, 0, 0);
    chk("done_after_last_bit", 64'(done0), 64'd1);
  endtask

  logic [NB-1:0] v_and4, v_st1, v_st2, v_fb, v_ones;

  initial begin
    v_and4 = mk(2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 1'b0, 16'h0000, 16'h8000);
    v_st1  = mk(2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0, 16'h0000, 16'hFFFF);
    v_st2  = mk(2'b01, 2'b00, 2'b00, 2'b01, 2'b10, 1'b0, 16'hAAAA, 16'h0000);
    v_fb   = mk(2'b10, 2'b10, 2'b10, 2'b00, 2'b10, 1'b1, 16'h0000, 16'h5555);
    v_ones = '1;

    // Reset held with the chain enabled and data high.
    RST = 1'b1; CFG_EN = 1'b1; CFG_DIN = 1'b1; IN = 4'h0;
    tick();
    tick();
    chk("rst_done", 64'(done0), 64'd0);
    chk("rst_x", 64'(x0), 64'd0);
    chk("rst_y", 64'(y0), 64'd0);
    chk("rst_q", 64'(q0), 64'd0);
    chk("rst_dout", 64'(dout0), 64'd0);
    chk("rst_cnt", 64'(u0.cnt_q), 64'd0);
    RST = 1'b0; CFG_EN = 1'b0; CFG_DIN = 1'b0;

    // Reset in the middle of a load discards the partial configuration.
    shift_rng(v_ones, NB - 1, NB - 5);
    chk("midload_cnt", 64'(u0.cnt_q), 64'd5);
    chk("midload_dout", 64'(dout0), 64'd0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("midrst_cnt", 64'(u0.cnt_q), 64'd0);
    chk("midrst_cfg", 64'(u0.cfg_q), 64'd0);
    chk("midrst_done", 64'(done0), 64'd0);

    // Paused load of the AND4 configuration.
    shift_rng(v_and4, NB - 1, NB - 20);
    chk("pause_cnt", 64'(u0.cnt_q), 64'd20);
    chk("pause_cfg", 64'(u0.cfg_q), 64'(v_and4 >> 23));
    IN = 4'hF;
    repeat (5) tick();
    chk("pause_cnt_hold", 64'(u0.cnt_q), 64'd20);
    chk("pause_cfg_hold", 64'(u0.cfg_q), 64'(v_and4 >> 23));
    chk("pause_done", 64'(done0), 64'd0);
    chk("pause_x", 64'(x0), 64'd0);
    chk("pause_y", 64'(y0), 64'd0);
    shift_rng(v_and4, NB - 21, 1);
    chk("resume_done_bit42", 64'(done0), 64'd0);
    shift_rng(v_and4, 0, 0);
    chk("resume_done_bit43", 64'(done0), 64'd1);
    chk("resume_cfg", 64'(u0.cfg_q), 64'(v_and4));

    // AND4 function.
    IN = 4'hF; #1;
    chk("and4_x_F", 64'(x0), 64'd1);
    chk("and4_y_F", 64'(y0), 64'd1);
    tick();
    chk("and4_q_F", 64'(q0), 64'd1);
    IN = 4'hE; #1;
    chk("and4_x_E", 64'(x0), 64'd0);
    chk("and4_y_E", 64'(y0), 64'd0);
    tick();
    chk("and4_q_E", 64'(q0), 64'd0);

    // Storage element: reset input from IN[1], F all ones.
    load(v_st1);
    IN = 4'h0; #1;
    chk("st1_q_init", 64'(q0), 64'd0);
    tick();
    chk("st1_q_set_by_f", 64'(q0), 64'd1);
    chk("st1_x_is_q", 64'(x0), 64'd1);
    IN = 4'h2;
    tick();
    chk("st1_q_reset", 64'(q0), 64'd0);
    chk("st1_y_is_q", 64'(y0), 64'd0);

    // Storage element: S=IN[3], R=IN[1], E=IN[3], F=0, Y=G.
    load(v_st2);
    IN = 4'h8;
    tick();
    chk("st2_q_set", 64'(q0), 64'd1);
    IN = 4'h0;
    tick();
    chk("st2_q_hold_e0", 64'(q0), 64'd1);
    IN = 4'h1; #1;
    chk("st2_y_g1", 64'(y0), 64'd1);
    IN = 4'h0; #1;
    chk("st2_y_g0", 64'(y0), 64'd0);
    IN = 4'hA;
    tick();
    chk("st2_r_dominates", 64'(q0), 64'd0);
    chk("st2_x_is_q", 64'(x0), 64'd0);

    // Feedback toggle: F = ~Q.
    load(v_fb);
    IN = 4'h0; #1;
    chk("fb_x0", 64'(x0), 64'd0);
    tick();
    chk("fb_x1", 64'(x0), 64'd1);
    tick();
    chk("fb_x2", 64'(x0), 64'd0);
    tick();
    chk("fb_x3", 64'(x0), 64'd1);

    // Two-tile chain: the first 43 bits sent end up in the downstream tile.
    RST = 1'b1;
    tick();
    RST = 1'b0;
    shift_rng(v_fb, NB - 1, 0);
    shift_rng(v_and4, NB - 1, 0);
    chk("chain_done0", 64'(done0), 64'd1);
    chk("chain_done1", 64'(done1), 64'd1);
    chk("chain_cfg0", 64'(u0.cfg_q), 64'(v_and4));
    chk("chain_cfg1", 64'(u1.cfg_q), 64'(v_fb));
    IN = 4'hF; #1;
    chk("chain_x0", 64'(x0), 64'd1);
    chk("chain_x1", 64'(x1), 64'd0);
    tick();
    chk("chain_q0", 64'(q0), 64'd1);
    chk("chain_q1", 64'(q1), 64'd1);
    CFG_EN = 1'b1; CFG_DIN = 1'b0;
    tick();
    CFG_EN = 1'b0;
    chk("reconf_done0", 64'(done0), 64'd0);
    chk("reconf_done1", 64'(done1), 64'd0);
    chk("reconf_q0", 64'(q0), 64'd0);
    chk("reconf_q1", 64'(q1), 64'd0);
    chk("reconf_cnt0", 64'(u0.cnt_q), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clb_cfg.md
# clb_cfg

Parametrised configurable logic block: two N_IN-input LUTs (F, G), a set/reset/enable storage element and output muxes. Every function select is loaded at run time from a serial configuration chain. Blocks daisy-chain through CFG_DOUT to form a configurable array. This is the fabric tile's next generation: width is generic, the configuration is loadable, and everything runs on a single clock.

## Interface
- N_IN, default 4: LUT input count, legal 2..6; LUT_BITS = 2**N_IN.
- CFG_BITS, derived 2*LUT_BITS+11 (43 at default): total configuration length.
- K  in  1  clock; all state changes on posedge K.
- RST  in  1  synchronous, active-high reset.
- IN  in  N_IN  user logic inputs.
- CFG_EN  in  1  shift-enable for configuration chain.
- CFG_DIN  in  1  serial config data, sampled when CFG_EN=1.
- CFG_DOUT  out  1  cfg[CFG_BITS-1], for daisy-chaining the next block.
- CFG_DONE  out  1  high while configured (state CONF).
- X  out  1  user output X.
- Y  out  1  user output Y.
- Q  out  1  storage-element state.

## Operation
- Config register cfg[CFG_BITS-1:0] shifts left on each K edge with CFG_EN=1: cfg <= {cfg[CFG_BITS-2:0], CFG_DIN}. The first bit sent ends at the MSB.
- Field map:
  - [LUT_BITS-1:0] F table.
  - [2L-1:L] G table.
  - [2L] FBSEL.
  - [2L+2:2L+1] XSEL.
  - [2L+4:2L+3] YSEL.
  - [2L+6:2L+5] SSEL.
  - [2L+8:2L+7] RSEL.
  - [2L+10:2L+9] ESEL.
- LUT address = {IN[N_IN-1:1], D}, where D = FBSEL ? Q : IN[0]. F = Ftable[addr], G = Gtable[addr].
- S = SSEL 00: IN[N_IN-1]; 01: F; 1x: 0.
- R = RSEL 00: IN[1]; 01: G; 1x: 0.
- E = ESEL 00: G; 01: IN[N_IN-1]; 1x: 1.
- X = XSEL 00: F; 01: G; 1x: Q.
- Y = YSEL 00: Q; 01: G; 1x: F.
- Storage element: on posedge K in CONF with E=1:
  - R=1 → Q<=0 (R dominates S).
  - else S=1 → Q<=1.
  - else Q<=F.
- When E=0, Q holds.
- FSM states: UNCONF, LOAD, CONF.
  - UNCONF: CFG_EN=1 → shift, cnt<=1, go LOAD.
  - LOAD: CFG_EN=1 → shift, cnt++. When the shift brings cnt to CFG_BITS → CONF, cnt<=0. CFG_EN=0 → pause; cnt and cfg hold.
  - CONF: CFG_EN=1 → reconfiguration. Shift the bit, cnt<=1, Q<=0, go LOAD.
- Outside CONF: X=0, Y=0, Q held at 0, CFG_DONE=0. CFG_DOUT always reflects cfg MSB, so the chain passes through during LOAD.
- cnt width = clog2(CFG_BITS+1). cnt never exceeds CFG_BITS.

## Timing
- RST (synchronous, priority over all) → state UNCONF, cfg=0, cnt=0, Q=0, CFG_DONE=0, X=0, Y=0, CFG_DOUT=0.
- Configuration takes exactly CFG_BITS enabled edges. CFG_DONE rises on the edge that samples the last bit and is visible in the following cycle.
- F, G, X and Y are combinational from IN, Q and cfg, with zero-cycle latency in CONF.
- Q updates one edge after S/R/E/F are presented. With FBSEL=1, the new Q affects F in the next cycle only; there is no combinational loop.
- CFG_EN asserted in the same cycle CONF is entered (cycle after last bit) counts as a reconfiguration start.
- RST asserted mid-LOAD discards the partial config; the next load restarts at cnt=0.

## Test plan
- Reset: hold RST 2 cycles with CFG_EN=1 → CFG_DONE=0, X=Y=Q=0, CFG_DOUT=0; cnt stays 0.
- AND4 load (N_IN=4): shift 43 bits giving F=16'h8000, XSEL=00, YSEL=1x, other selects 1x, FBSEL=0 → CFG_DONE=1 after bit 43.
  - IN=4'hF → X=1, Y=1.
  - IN=4'hE → X=0.
- Paused load: drop CFG_EN for 5 cycles after bit 20 → CFG_DONE stays 0 and cfg unchanged. Resume → CFG_DONE only after bit 43 total.
- Storage element: F=16'hFFFF, SSEL=1x, RSEL=00, ESEL=1x.
  - IN[1]=0 → Q=1 one edge later.
  - IN[1]=1 → Q=0 next edge.
  - Set S=1 and R=1 together → Q=0.
- Feedback toggle: FBSEL=1, F table = ~D (16'h5555), ESEL=1x, XSEL=1x → X toggles 0,1,0,1 on successive edges.
- Reconfigure/chain: two blocks chained via CFG_DOUT, 86 bits shifted → both CFG_DONE=1, with the first-sent 43 bits landing in the downstream block. Then CFG_EN=1 in CONF → CFG_DONE=0 and Q=0 next cycle.
